// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

   // Access sequencing: every granted access takes exactly three cycles.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Requester identifiers; also used as bit positions in request vectors.
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen. Port A can be masked out, which is how the port B lock works.
module rr_pick2
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       mask_a,
   output logic       gnt_valid,
   output logic       gnt_id
);

   logic [1:0] elig;

   // Winner selection from the eligible requests and the previous owner.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      elig      = {req[PORT_B], req[PORT_A] & ~mask_a};
      gnt_valid = |elig;
      gnt_id    = PORT_A;
      if (elig == 2'b11) begin
         gnt_id = ~last;
      end else if (elig[PORT_B]) begin
         gnt_id = PORT_B;
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// Shares a single-port data memory between the CPU path (port A) and a
// debug/loader port (port B). Each access runs IDLE -> ISSUE -> RESP, with
// round-robin arbitration, an exclusive lock for port B and saturating
// per-port completion counters.
module dm_arbiter
   import dm_arb_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              a_req_i,
   input  logic              a_we_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_wdata_i,
   output logic              a_ack_o,
   output logic [DATA_W-1:0] a_rdata_o,
   input  logic              b_req_i,
   input  logic              b_we_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_wdata_i,
   output logic              b_ack_o,
   output logic [DATA_W-1:0] b_rdata_o,
   input  logic              b_lock_i,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o,
   output logic              owner_b_o,
   output logic [CNT_W-1:0]  a_cnt_o,
   output logic [CNT_W-1:0]  b_cnt_o
);

   state_t              state_q;
   state_t              state_d;
   logic                grant;
   logic                gnt_valid;
   logic                gnt_id;
   logic                owner_q;   // doubles as last_grant for round-robin
   logic                lock_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    a_cnt_q;
   logic [CNT_W-1:0]    b_cnt_q;
   logic                resp_live;

   // While locked, port A is masked so only port B can win.
   rr_pick2 u_pick (
      .req       ({b_req_i, a_req_i}),
      .last      (owner_q),
      .mask_a    (lock_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Next-state logic; a grant is only taken from IDLE.
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               grant   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignment so all registers update together.
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture the winner's request fields; they are frozen until the next grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= PORT_B;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant) begin
         owner_q <= gnt_id;
         if (gnt_id == PORT_B) begin
            we_q    <= b_we_i;
            addr_q  <= b_addr_i;
            wdata_q <= b_wdata_i;
         end else begin
            we_q    <= a_we_i;
            addr_q  <= a_addr_i;
            wdata_q <= a_wdata_i;
         end
      end
   end

   // Lock: armed by a locked port B grant, released by any IDLE cycle without b_lock_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= 1'b0;
      end else if (state_q == IDLE) begin
         if (grant && (gnt_id == PORT_B) && b_lock_i) begin
            lock_q <= 1'b1;
         end else if (!b_lock_i) begin
            lock_q <= 1'b0;
         end
      end
   end

   // Saturating completion counters, bumped in the owner's RESP cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_cnt_q <= '0;
         b_cnt_q <= '0;
      end else if (state_q == RESP) begin
         if (owner_q == PORT_A) begin
            if (a_cnt_q != '1) a_cnt_q <= a_cnt_q + CNT_W'(1);
         end else begin
            if (b_cnt_q != '1) b_cnt_q <= b_cnt_q + CNT_W'(1);
         end
      end
   end

   // Reset in ISSUE or RESP aborts the access: the memory strobe and the ack
   // are suppressed in that same cycle so nothing is committed or reported.
   assign resp_live   = (state_q == RESP) && !rst_i;
   assign a_ack_o     = resp_live && (owner_q == PORT_A);
   assign b_ack_o     = resp_live && (owner_q == PORT_B);
   assign a_rdata_o   = (a_ack_o && !we_q) ? mem_rdata_i : '0;
   assign b_rdata_o   = (b_ack_o && !we_q) ? mem_rdata_i : '0;

   assign mem_en_o    = (state_q == ISSUE) && !rst_i;
   assign mem_we_o    = we_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

   assign busy_o      = (state_q != IDLE);
   assign owner_b_o   = owner_q;
   assign a_cnt_o     = a_cnt_q;
   assign b_cnt_o     = b_cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus a randomized
// phase, all compared every cycle against a transaction-level model.
module tb_dm_arbiter;
   import dm_arb_pkg::*;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 5;
   localparam int CNT_W  = 16;
   localparam int SAT_W  = 2;

   typedef struct {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } txn_t;

   typedef struct {
      int                port;
      int                cyc;
      logic [DATA_W-1:0] rdata;
   } ack_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_i = 1'b1;
   logic              a_req_i = 1'b0, a_we_i = 1'b0;
   logic [ADDR_W-1:0] a_addr_i = '0;
   logic [DATA_W-1:0] a_wdata_i = '0;
   logic              b_req_i = 1'b0, b_we_i = 1'b0, b_lock_i = 1'b0;
   logic [ADDR_W-1:0] b_addr_i = '0;
   logic [DATA_W-1:0] b_wdata_i = '0;

   logic              a_ack_o, b_ack_o, mem_en_o, mem_we_o, busy_o, owner_b_o;
   logic [DATA_W-1:0] a_rdata_o, b_rdata_o, mem_wdata_o, mem_rdata_i;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [CNT_W-1:0]  a_cnt_o, b_cnt_o;

   logic              s_a_ack, s_b_ack, s_mem_en, s_mem_we, s_busy, s_owner_b;
   logic [DATA_W-1:0] s_a_rdata, s_b_rdata, s_mem_wdata;
   logic [ADDR_W-1:0] s_mem_addr;
   logic [SAT_W-1:0]  s_a_cnt, s_b_cnt;

   dm_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
      .a_ack_o(a_ack_o), .a_rdata_o(a_rdata_o),
      .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
      .b_ack_o(b_ack_o), .b_rdata_o(b_rdata_o), .b_lock_i(b_lock_i),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .owner_b_o(owner_b_o), .a_cnt_o(a_cnt_o), .b_cnt_o(b_cnt_o)
   );

   // Narrow-counter instance driven in lockstep to exercise saturation.
   dm_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) u_sat (
      .clk_i(clk), .rst_i(rst_i),
      .a_req_i(a_req_i), .a_we_i(a_we_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
      .a_ack_o(s_a_ack), .a_rdata_o(s_a_rdata),
      .b_req_i(b_req_i), .b_we_i(b_we_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
      .b_ack_o(s_b_ack), .b_rdata_o(s_b_rdata), .b_lock_i(b_lock_i),
      .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
      .mem_wdata_o(s_mem_wdata), .mem_rdata_i(mem_rdata_i),
      .busy_o(s_busy), .owner_b_o(s_owner_b), .a_cnt_o(s_a_cnt), .b_cnt_o(s_b_cnt)
   );

   // Single-port data memory seen by the main instance; read data one cycle after the strobe.
   logic [DATA_W-1:0] dm [32] = '{default: '0};
   logic [DATA_W-1:0] dm_rdata = '0;
   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) dm[mem_addr_o] <= mem_wdata_o;
         dm_rdata <= dm[mem_addr_o];
      end
   end
   assign mem_rdata_i = dm_rdata;

   // Reference model state: access progress, owner, lock, counts, expected memory.
   int                m_phase = 0;     // 0 idle, 1 strobe cycle, 2 response cycle
   int                m_owner = 1;
   int                m_lock  = 0;
   int                m_cnt [2] = '{0, 0};
   txn_t              m_txn;
   logic [DATA_W-1:0] ref_mem [32] = '{default: '0};

   txn_t qa [$];
   txn_t qb [$];
   ack_t log_q [$];
   int   cyc = 1;
   int   en_cnt = 0;
   bit   b_seen = 0;
   bit   lock_auto = 0;
   int   tests = 0;
   int   fails = 0;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic int sat(int v, int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      a_req_i = (qa.size() != 0);
      if (a_req_i) begin
         a_we_i = qa[0].we; a_addr_i = qa[0].addr; a_wdata_i = qa[0].wdata;
      end
      b_req_i = (qb.size() != 0);
      if (b_req_i) begin
         b_we_i = qb[0].we; b_addr_i = qb[0].addr; b_wdata_i = qb[0].wdata;
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = ADDR_W'($urandom_range(0, 31));
      t.wdata = DATA_W'($urandom);
      return t;
   endfunction

   // One clock: compare outputs with the model mid-cycle, then advance the model.
   task automatic tick();
      logic              x_en, x_ack_a, x_ack_b;
      logic [DATA_W-1:0] x_rd_a, x_rd_b;
      int                n_phase, n_owner, n_lock, done, w;
      bit                ea, eb;
      txn_t              n_txn;

      @(negedge clk);
      x_en    = (m_phase == 1) && !rst_i;
      x_ack_a = (m_phase == 2) && (m_owner == 0) && !rst_i;
      x_ack_b = (m_phase == 2) && (m_owner == 1) && !rst_i;
      x_rd_a  = (x_ack_a && !m_txn.we) ? ref_mem[m_txn.addr] : '0;
      x_rd_b  = (x_ack_b && !m_txn.we) ? ref_mem[m_txn.addr] : '0;

      check("busy",    32'(busy_o),    32'(m_phase != 0));
      check("mem_en",  32'(mem_en_o),  32'(x_en));
      check("a_ack",   32'(a_ack_o),   32'(x_ack_a));
      check("b_ack",   32'(b_ack_o),   32'(x_ack_b));
      check("a_rdata", 32'(a_rdata_o), 32'(x_rd_a));
      check("b_rdata", 32'(b_rdata_o), 32'(x_rd_b));
      check("owner_b", 32'(owner_b_o), m_owner);
      check("a_cnt",   32'(a_cnt_o),   sat(m_cnt[0], 65535));
      check("b_cnt",   32'(b_cnt_o),   sat(m_cnt[1], 65535));
      check("s_busy",  32'(s_busy),    32'(m_phase != 0));
      check("s_mem_en", 32'(s_mem_en), 32'(x_en));
      check("s_a_ack", 32'({s_a_ack, s_a_rdata}), 32'({x_ack_a, x_rd_a}));
      check("s_b_ack", 32'({s_b_ack, s_b_rdata}), 32'({x_ack_b, x_rd_b}));
      check("s_owner_b", 32'(s_owner_b), m_owner);
      check("s_a_cnt", 32'(s_a_cnt),   sat(m_cnt[0], 3));
      check("s_b_cnt", 32'(s_b_cnt),   sat(m_cnt[1], 3));
      if (x_en) begin
         check("mem_we",    32'(mem_we_o),    32'(m_txn.we));
         check("mem_addr",  32'(mem_addr_o),  32'(m_txn.addr));
         check("mem_wdata", 32'(mem_wdata_o), 32'(m_txn.wdata));
         check("s_mem_fields", 32'({s_mem_we, s_mem_addr, s_mem_wdata}),
               32'({m_txn.we, m_txn.addr, m_txn.wdata}));
      end
      if (mem_en_o) en_cnt++;
      if (a_ack_o) log_q.push_back('{0, cyc, a_rdata_o});
      if (b_ack_o) begin
         log_q.push_back('{1, cyc, b_rdata_o});
         b_seen = 1;
      end

      n_phase = m_phase; n_owner = m_owner; n_lock = m_lock; n_txn = m_txn; done = -1;
      if (rst_i) begin
         n_phase = 0; n_owner = 1; n_lock = 0;
      end else if (m_phase == 0) begin
         if (!b_lock_i) n_lock = 0;
         ea = a_req_i && (m_lock == 0);
         eb = b_req_i;
         w  = -1;
         if (ea && eb)  w = 1 - m_owner;
         else if (ea)   w = 0;
         else if (eb)   w = 1;
         if (w >= 0) begin
            n_phase = 1;
            n_owner = w;
            n_txn   = (w == 0) ? qa[0] : qb[0];
            if (w == 1 && b_lock_i) n_lock = 1;
         end
      end else if (m_phase == 1) begin
         n_phase = 2;
      end else begin
         n_phase = 0;
         done    = m_owner;
      end

      @(posedge clk);
      #1;
      if (rst_i) begin
         m_cnt[0] = 0; m_cnt[1] = 0;
         qa.delete(); qb.delete();
      end else if (done >= 0) begin
         m_cnt[done]++;
         if (m_txn.we) ref_mem[m_txn.addr] = m_txn.wdata;
         if (done == 0) void'(qa.pop_front());
         else           void'(qb.pop_front());
         if (lock_auto && qb.size() == 0) begin
            b_lock_i  = 1'b0;
            lock_auto = 0;
         end
      end
      m_phase = n_phase; m_owner = n_owner; m_lock = n_lock; m_txn = n_txn;
      cyc++;
      drive();
   endtask

   task automatic do_reset();
      b_lock_i  = 1'b0;
      lock_auto = 0;
      rst_i     = 1'b1;
      tick();
      rst_i     = 1'b0;
      log_q.delete();
      cyc    = 1;
      en_cnt = 0;
      b_seen = 0;
   endtask

   task automatic drain(int limit);
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0 || m_phase != 0) && n < limit) begin
         tick();
         n++;
      end
      check("drain_bound", 32'(n < limit), 1);
   endtask

   initial begin
      // Reset, then reset-state checks.
      do_reset();
      check("rst_busy",  32'(busy_o), 0);
      check("rst_mem",   32'({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}), 0);
      check("rst_ack",   32'({a_ack_o, b_ack_o, a_rdata_o}), 0);
      check("rst_cnt",   32'({a_cnt_o, b_cnt_o}), 0);
      check("rst_owner", 32'(owner_b_o), 1);

      // Single write then read-back on port A.
      qa.push_back('{1'b1, 5'd3, 16'h00A5});
      drive();
      drain(50);
      check("t1_en_cycles", en_cnt, 1);
      check("t1_nacks", log_q.size(), 1);
      if (log_q.size() >= 1) check("t1_ack_cycle", log_q[0].cyc, 3);
      qa.push_back('{1'b0, 5'd3, 16'h0000});
      drive();
      drain(50);
      check("t1_nacks2", log_q.size(), 2);
      if (log_q.size() >= 2) check("t1_rdata", 32'(log_q[1].rdata), 32'h00A5);
      check("t1_a_cnt", 32'(a_cnt_o), 2);

      // Simultaneous requests: A first, then strict alternation.
      do_reset();
      qa.push_back('{1'b0, 5'd1, 16'h0}); qb.push_back('{1'b0, 5'd2, 16'h0});
      qa.push_back('{1'b0, 5'd4, 16'h0}); qb.push_back('{1'b0, 5'd6, 16'h0});
      qa.push_back('{1'b0, 5'd5, 16'h0}); qb.push_back('{1'b0, 5'd3, 16'h0});
      drive();
      drain(100);
      check("t2_nacks", log_q.size(), 6);
      if (log_q.size() == 6) begin
         for (int i = 0; i < 6; i++) check("t2_order", log_q[i].port, i % 2);
         check("t2_a_cycle", log_q[0].cyc, 3);
         check("t2_b_cycle", log_q[1].cyc, 6);
      end

      // Locked burst from B while A requests continuously.
      do_reset();
      b_lock_i  = 1'b1;
      lock_auto = 1;
      for (int i = 0; i < 4; i++) qb.push_back('{1'b1, ADDR_W'(i), DATA_W'(16'hB000 + i)});
      drive();
      tick();
      qa.push_back('{1'b0, 5'd0, 16'h0});
      qa.push_back('{1'b0, 5'd1, 16'h0});
      drive();
      drain(200);
      check("t3_nacks", log_q.size(), 6);
      if (log_q.size() == 6) begin
         for (int i = 0; i < 4; i++) check("t3_b_first", log_q[i].port, 1);
         check("t3_a_next", log_q[4].port, 0);
         check("t3_a_rdata", 32'(log_q[4].rdata), 32'hB000);
      end
      check("t3_b_cnt", 32'(b_cnt_o), 4);

      // Reset during the strobe cycle of a B write.
      do_reset();
      qb.push_back('{1'b1, 5'd7, 16'h1234});
      drive();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check("t4_busy",   32'(busy_o), 0);
      check("t4_b_cnt",  32'(b_cnt_o), 0);
      check("t4_no_ack", 32'(b_seen), 0);
      log_q.delete();
      qa.push_back('{1'b0, 5'd7, 16'h0});
      drive();
      drain(50);
      check("t4_nacks", log_q.size(), 1);
      if (log_q.size() == 1) check("t4_not_committed", 32'(log_q[0].rdata != 16'h1234), 1);

      // Counter saturation on the narrow instance.
      do_reset();
      for (int i = 0; i < 5; i++) qa.push_back(rand_txn());
      drive();
      drain(100);
      check("t5_sat_cnt", 32'(s_a_cnt), 3);
      check("t5_full_cnt", 32'(a_cnt_o), 5);

      // Write ack carries zero read data; port B stays silent.
      do_reset();
      qa.push_back('{1'b1, 5'd9, 16'hBEEF});
      drive();
      drain(50);
      check("t6_nacks", log_q.size(), 1);
      if (log_q.size() == 1) check("t6_wr_rdata", 32'(log_q[0].rdata), 0);
      check("t6_b_quiet", 32'(b_seen), 0);

      // Randomized traffic with lock toggling.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (qa.size() == 0 && $urandom_range(0, 2) == 0) qa.push_back(rand_txn());
         if (qb.size() == 0 && $urandom_range(0, 2) == 0) qb.push_back(rand_txn());
         if ($urandom_range(0, 5) == 0) b_lock_i = ~b_lock_i;
         drive();
         tick();
      end
      b_lock_i = 1'b0;
      drain(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
